// File: rtl/led_mode_sequencer_if.sv
// Button/LED bus between the board pads and led_mode_sequencer.
// Raw buttons travel towards the sequencer; LEDs and the debug mode travel back out.
interface led_mode_sequencer_if;
   logic       but1;
   logic       but2;
   logic       led1;
   logic       led2;
   logic [2:0] mode;

   modport master (output but1, output but2, input led1, input led2, input mode);
   modport slave  (input but1, input but2, output led1, output led2, output mode);
endinterface

// File: rtl/led_mode_sequencer.sv
// Button -> LED controller: synchronise, debounce and edge-detect two buttons,
// then step a five-state mode FSM that drives two LEDs, including an alternate-blink mode.
module led_mode_sequencer #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int BLINK_CYCLES    = 5000000,
   parameter bit BUT_ACTIVE_LOW  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   led_mode_sequencer_if.slave bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BW = $clog2(BLINK_CYCLES);

   typedef enum logic [2:0] {
      S_OFF  = 3'd0,
      S_L1   = 3'd1,
      S_L2   = 3'd2,
      S_BOTH = 3'd3,
      S_ALT  = 3'd4
   } state_t;

   logic [1:0] raw;
   logic [1:0] pulse;

   // bit 0 = BUT1 (advance), bit 1 = BUT2 (return to OFF)
   assign raw = {bus.but2, bus.but1};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic          sync1_reg;
         logic          sync2_reg;
         logic          stable_reg;
         logic          stable_d_reg;
         logic          pulse_reg;
         logic [DW-1:0] db_cnt_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               sync1_reg    <= 1'b0;
               sync2_reg    <= 1'b0;
               stable_reg   <= 1'b0;
               stable_d_reg <= 1'b0;
               pulse_reg    <= 1'b0;
               db_cnt_reg   <= '0;
            end else begin
               sync1_reg    <= BUT_ACTIVE_LOW ? ~raw[gi] : raw[gi];
               sync2_reg    <= sync1_reg;
               stable_d_reg <= stable_reg;
               pulse_reg    <= stable_reg & ~stable_d_reg;
               // Any agreement restarts the count, so only an unbroken run is accepted.
               if (sync2_reg == stable_reg) begin
                  db_cnt_reg <= '0;
               end else if (db_cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
                  stable_reg <= sync2_reg;
                  db_cnt_reg <= '0;
               end else begin
                  db_cnt_reg <= db_cnt_reg + 1'b1;
               end
            end
         end

         assign pulse[gi] = pulse_reg;
      end
   endgenerate

   state_t        state_reg;
   state_t        state_next;
   logic [BW-1:0] blink_cnt_reg;
   logic [BW-1:0] blink_cnt_next;
   logic          phase_reg;
   logic          phase_next;
   logic          led1_reg;
   logic          led1_next;
   logic          led2_reg;
   logic          led2_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_OFF;
         blink_cnt_reg <= '0;
         phase_reg     <= 1'b0;
         led1_reg      <= 1'b0;
         led2_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         blink_cnt_reg <= blink_cnt_next;
         phase_reg     <= phase_next;
         led1_reg      <= led1_next;
         led2_reg      <= led2_next;
      end
   end

   always_comb begin
      state_next = S_OFF;
      case (state_reg)
         S_OFF:   state_next = pulse[0] ? S_L1   : S_OFF;
         S_L1:    state_next = pulse[0] ? S_L2   : S_L1;
         S_L2:    state_next = pulse[0] ? S_BOTH : S_L2;
         S_BOTH:  state_next = pulse[0] ? S_ALT  : S_BOTH;
         S_ALT:   state_next = pulse[0] ? S_OFF  : S_ALT;
         default: state_next = S_OFF;
      endcase
      if (pulse[1]) begin
         state_next = S_OFF;
      end
   end

   // Blink state is advanced only while staying in ALT, so every entry starts from zero.
   always_comb begin
      blink_cnt_next = '0;
      phase_next     = 1'b0;
      if (state_reg == S_ALT && state_next == S_ALT) begin
         if (blink_cnt_reg == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
         end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
            phase_next     = phase_reg;
         end
      end
   end

   always_comb begin
      led1_next = 1'b0;
      led2_next = 1'b0;
      case (state_next)
         S_L1: begin
            led1_next = 1'b1;
         end
         S_L2: begin
            led2_next = 1'b1;
         end
         S_BOTH: begin
            led1_next = 1'b1;
            led2_next = 1'b1;
         end
         S_ALT: begin
            led1_next = phase_next;
            led2_next = ~phase_next;
         end
         default: begin
            led1_next = 1'b0;
            led2_next = 1'b0;
         end
      endcase
   end

   assign bus.led1 = led1_reg;
   assign bus.led2 = led2_reg;
   assign bus.mode = state_reg;
endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: directed scenarios plus random button activity,
// all checked cycle by cycle against a rule-level model of debounce, mode stepping and blinking.
module tb_led_mode_sequencer;
   localparam int D = 4;
   localparam int B = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errors  = 0;

   led_mode_sequencer_if bus ();

   led_mode_sequencer #(
      .DEBOUNCE_CYCLES (D),
      .BLINK_CYCLES    (B),
      .BUT_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   wire [4:0] dut_out = {bus.mode, bus.led1, bus.led2};

   // Model state: raw pressed history, synced-level window, stable-level history.
   bit raw_h    [2][2];
   bit win      [2][D];
   bit st_h     [2][3];
   bit stable_m [2];
   int mode_m    = 0;
   int alt_start = 0;
   int edge_n    = 0;
   bit led1_m    = 1'b0;
   bit led2_m    = 1'b0;

   function automatic logic [4:0] model_out();
      logic [4:0] v;
      v = {mode_m[2:0], led1_m, led2_m};
      return v;
   endfunction

   // One clock edge of the reference: a level is accepted after D identical synced
   // samples that differ from the accepted level; a press is a released->pressed step.
   task automatic model_edge(input bit r, input bit p0, input bit p1);
      bit p     [2];
      bit pls   [2];
      bit syn;
      bit all_mis;
      int old_mode;
      edge_n++;
      p[0] = p0;
      p[1] = p1;
      if (r) begin
         for (int b = 0; b < 2; b++) begin
            raw_h[b][0] = 1'b0; raw_h[b][1] = 1'b0;
            for (int i = 0; i < D; i++) win[b][i] = 1'b0;
            for (int i = 0; i < 3; i++) st_h[b][i] = 1'b0;
            stable_m[b] = 1'b0;
         end
         mode_m = 0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            pls[b] = st_h[b][1] & ~st_h[b][2];
            syn = raw_h[b][1];
            for (int i = D - 1; i > 0; i--) win[b][i] = win[b][i-1];
            win[b][0] = syn;
            all_mis = 1'b1;
            for (int i = 0; i < D; i++) if (win[b][i] == stable_m[b]) all_mis = 1'b0;
            if (all_mis) stable_m[b] = ~stable_m[b];
            st_h[b][2] = st_h[b][1];
            st_h[b][1] = st_h[b][0];
            st_h[b][0] = stable_m[b];
            raw_h[b][1] = raw_h[b][0];
            raw_h[b][0] = p[b];
         end
         old_mode = mode_m;
         if (pls[1]) mode_m = 0;
         else if (pls[0]) mode_m = (mode_m + 1) % 5;
         if (mode_m == 4 && old_mode != 4) alt_start = edge_n;
      end
      case (mode_m)
         1: begin led1_m = 1'b1; led2_m = 1'b0; end
         2: begin led1_m = 1'b0; led2_m = 1'b1; end
         3: begin led1_m = 1'b1; led2_m = 1'b1; end
         4: begin
            led1_m = (((edge_n - alt_start) / B) % 2) == 1;
            led2_m = ~led1_m;
         end
         default: begin led1_m = 1'b0; led2_m = 1'b0; end
      endcase
   endtask

   // Drive raw levels (0 = pressed), advance one edge, compare against the model.
   task automatic tick(input bit r, input bit b1, input bit b2);
      rst      = r;
      bus.but1 = b1;
      bus.but2 = b2;
      @(posedge clk);
      model_edge(rst, ~bus.but1, ~bus.but2);
      #1;
      vectors++;
      if (dut_out !== model_out()) begin
         errors++;
         $display("FAIL model t=%0t: mode/led1/led2 got %0d/%b/%b expected %0d/%b/%b",
                  $time, bus.mode, bus.led1, bus.led2, mode_m, led1_m, led2_m);
      end
   endtask

   task automatic press(input int btn, input int hold, input int gap);
      for (int i = 0; i < hold; i++) tick(1'b0, btn[0] ? 1'b0 : 1'b1, btn[1] ? 1'b0 : 1'b1);
      for (int i = 0; i < gap; i++) tick(1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 9; i++) begin
         tick(i < 3, 1'b1, 1'b1);
         vectors++;
         if (dut_out !== 5'b000_00) begin
            errors++;
            $display("FAIL reset cycle %0d: mode/leds got %b required 000_00", i, dut_out);
         end
      end
   endtask

   task automatic test_bounce();
      for (int rep = 0; rep < 5; rep++) begin
         for (int i = 0; i < 5; i++) begin
            tick(1'b0, (i < 3) ? 1'b0 : 1'b1, 1'b1);
            vectors++;
            if (bus.mode !== 3'd0) begin
               errors++;
               $display("FAIL bounce rep %0d: mode got %0d required 0", rep, bus.mode);
            end
         end
      end
      press(0, 0, 10);
   endtask

   task automatic test_single_press();
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         vectors++;
         if (dut_out !== ((i >= 7) ? 5'b001_10 : 5'b000_00)) begin
            errors++;
            $display("FAIL latency edge k+%0d: mode/leds got %b required %b",
                     i, dut_out, (i >= 7) ? 5'b001_10 : 5'b000_00);
         end
      end
      press(0, 0, 15);
      vectors++;
      if (dut_out !== 5'b001_10) begin
         errors++;
         $display("FAIL hold_release: mode/leds got %b required 001_10", dut_out);
      end
   endtask

   task automatic test_mode_walk();
      logic [4:0] exp_tab [5];
      int t0;
      bit want;
      exp_tab[0] = 5'b001_10; exp_tab[1] = 5'b010_01; exp_tab[2] = 5'b011_11;
      exp_tab[3] = 5'b100_01; exp_tab[4] = 5'b000_00;
      press(2, 8, 12);
      for (int n = 0; n < 5; n++) begin
         if (n != 3) begin
            press(1, $urandom_range(6, 12), $urandom_range(8, 20));
            vectors++;
            if (dut_out !== exp_tab[n]) begin
               errors++;
               $display("FAIL walk step %0d: mode/leds got %b required %b", n, dut_out, exp_tab[n]);
            end
         end else begin
            t0 = -1;
            press(1, 6, 0);
            for (int t = 0; t < 60; t++) begin
               tick(1'b0, 1'b1, 1'b1);
               if (t0 < 0 && bus.mode === 3'd4) t0 = t;
               if (t0 >= 0) begin
                  want = (((t - t0) / B) % 2) == 1;
                  vectors++;
                  if (bus.led1 !== want || bus.led2 !== ~want) begin
                     errors++;
                     $display("FAIL alt_blink t=%0d: led1/led2 got %b/%b required %b/%b",
                              t - t0, bus.led1, bus.led2, want, ~want);
                  end
               end
            end
            vectors++;
            if (t0 < 0) begin
               errors++;
               $display("FAIL alt_entry: mode got %0d required 4 within bound", bus.mode);
            end
         end
      end
   endtask

   task automatic test_both_press();
      press(1, 8, 12);
      press(1, 8, 12);
      vectors++;
      if (bus.mode !== 3'd2) begin
         errors++;
         $display("FAIL both_setup: mode got %0d required 2", bus.mode);
      end
      press(3, 10, 12);
      vectors++;
      if (dut_out !== 5'b000_00) begin
         errors++;
         $display("FAIL both_press: mode/leds got %b required 000_00", dut_out);
      end
      press(2, 8, 12);
      vectors++;
      if (dut_out !== 5'b000_00) begin
         errors++;
         $display("FAIL but2_in_off: mode/leds got %b required 000_00", dut_out);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      vectors++;
      if (bus.mode !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid_clear: mode got %0d required 0", bus.mode);
      end
      for (int i = 0; i < 15; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         vectors++;
         if (bus.mode !== ((i >= 7) ? 3'd1 : 3'd0)) begin
            errors++;
            $display("FAIL reset_mid edge j+%0d: mode got %0d required %0d",
                     i, bus.mode, (i >= 7) ? 1 : 0);
         end
      end
      press(0, 0, 12);
   endtask

   task automatic test_random();
      bit b1 = 1'b1;
      bit b2 = 1'b1;
      int r1 = 0;
      int r2 = 0;
      for (int i = 0; i < 1500; i++) begin
         if (r1 == 0) begin
            b1 = $urandom_range(0, 1);
            r1 = $urandom_range(1, 12);
         end else r1--;
         if (r2 == 0) begin
            b2 = ($urandom_range(0, 3) != 0);
            r2 = $urandom_range(1, 12);
         end else r2--;
         tick($urandom_range(0, 299) == 0, b1, b2);
      end
   endtask

   initial begin
      bus.but1 = 1'b1;
      bus.but2 = 1'b1;
      test_reset();
      test_bounce();
      test_single_press();
      test_mode_walk();
      test_both_press();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
